// File: rtl/uart_receiver_pkg.sv
// Shared constants and types for the UART receive path: FIFO geometry,
// line-control bit positions and receiver state encodings.
package uart_receiver_pkg;

    localparam int UART_FIFO_REC_WIDTH = 11;
    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_POINTER_W = 4;
    localparam int UART_FIFO_COUNTER_W = 5;

    localparam int UART_LC_BITS_LO = 0;
    localparam int UART_LC_BITS_HI = 1;
    localparam int UART_LC_SB      = 2;
    localparam int UART_LC_PE      = 3;
    localparam int UART_LC_EP      = 4;
    localparam int UART_LC_SP      = 5;

    typedef enum logic [2:0] {
        SR_IDLE       = 3'd0,
        SR_REC_START  = 3'd1,
        SR_REC_BIT    = 3'd2,
        SR_REC_PARITY = 3'd3,
        SR_REC_STOP   = 3'd4,
        SR_PUSH       = 3'd5,
        SR_WAIT_HIGH  = 3'd6
    } rx_state_e;

    // Parity bit the transmitter should have sent for the given {EP,SP} mode.
    function automatic logic expected_parity(input logic [7:0] data, input logic ep, input logic sp);
        logic par;
        case ({ep, sp})
            2'b00:   par = ~^data;
            2'b01:   par = 1'b1;
            2'b10:   par = ^data;
            default: par = 1'b0;
        endcase
        return par;
    endfunction

endpackage

// File: rtl/uart_rfifo.sv
// 16-deep receive FIFO holding {data, parity error, framing error, break}
// entries, with a sticky overrun flag.
module uart_rfifo
    import uart_receiver_pkg::*;
(
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic                           push,
    input  logic                           pop,
    input  logic [UART_FIFO_REC_WIDTH-1:0] data_in,
    input  logic                           fifo_reset,
    input  logic                           reset_status,
    output logic [UART_FIFO_REC_WIDTH-1:0] data_out,
    output logic [UART_FIFO_COUNTER_W-1:0] count,
    output logic                           overrun
);

    logic [UART_FIFO_REC_WIDTH-1:0] mem_q [UART_FIFO_DEPTH];
    logic [UART_FIFO_POINTER_W-1:0] wr_ptr_q;
    logic [UART_FIFO_POINTER_W-1:0] rd_ptr_q;
    logic [UART_FIFO_COUNTER_W-1:0] count_q;
    logic                           overrun_q;
    logic                           full;
    logic                           empty;
    logic                           do_push;
    logic                           do_pop;

    assign full    = (count_q == UART_FIFO_COUNTER_W'(UART_FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees a slot in the same clk.
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; data_out is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !fifo_reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            overrun_q <= 1'b0;
        end else if (reset_status) begin
            overrun_q <= 1'b0;
        end else if (push && full && !do_pop) begin
            overrun_q <= 1'b1;
        end
    end

    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/uart_receiver.sv
// UART serial receive stage: synchronises the line, deframes characters at
// 16x oversampling, checks parity/framing/break and pushes into the receive FIFO.
module uart_receiver
    import uart_receiver_pkg::*;
(
    input  logic                           clk,
    input  logic                           wb_rst_i,
    input  logic [7:0]                     lcr,
    input  logic                           enable,
    input  logic                           srx_pad_i,
    input  logic                           rf_pop,
    input  logic                           rx_reset,
    input  logic                           lsr_mask,
    output logic [UART_FIFO_REC_WIDTH-1:0] rf_data_out,
    output logic [UART_FIFO_COUNTER_W-1:0] rf_count,
    output logic                           rf_overrun,
    output logic [2:0]                     rstate
);

    logic       srx_meta_q;
    logic       srx_q;
    rx_state_e  state_q, state_d;
    logic [4:0] counter_q, counter_d;
    logic [5:0] lcr_q, lcr_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_counter_q, bit_counter_d;
    logic       parity_bit_q, parity_bit_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;
    logic [3:0] char_bits;
    logic       brk;
    logic       rf_push;
    logic       unused_lcr_bits;

    logic [UART_FIFO_REC_WIDTH-1:0] rf_data_in;

    // Upper LCR bits belong to other blocks; the second stop bit is never checked.
    assign unused_lcr_bits = ^{lcr[7:6], lcr_q[UART_LC_SB]};

    // NOTE: sequential state uses <= so every flop sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            srx_meta_q <= 1'b1;
            srx_q      <= 1'b1;
        end else begin
            srx_meta_q <= srx_pad_i;
            srx_q      <= srx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= SR_IDLE;
            counter_q     <= '0;
            lcr_q         <= '0;
            shift_q       <= '0;
            bit_counter_q <= '0;
            parity_bit_q  <= 1'b0;
            pe_q          <= 1'b0;
            fe_q          <= 1'b0;
            bi_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            lcr_q         <= lcr_d;
            shift_q       <= shift_d;
            bit_counter_q <= bit_counter_d;
            parity_bit_q  <= parity_bit_d;
            pe_q          <= pe_d;
            fe_q          <= fe_d;
            bi_q          <= bi_d;
        end
    end

    assign char_bits = {2'b00, lcr_q[UART_LC_BITS_HI:UART_LC_BITS_LO]} + 4'd5;
    assign brk       = (shift_q == 8'h00) && (!lcr_q[UART_LC_PE] || !parity_bit_q) && !srx_q;

    always_comb begin
        // NOTE: every _d defaults to its _q, so no path through this block infers a latch.
        state_d       = state_q;
        counter_d     = counter_q;
        lcr_d         = lcr_q;
        shift_d       = shift_q;
        bit_counter_d = bit_counter_q;
        parity_bit_d  = parity_bit_q;
        pe_d          = pe_q;
        fe_d          = fe_q;
        bi_d          = bi_q;

        case (state_q)
            SR_IDLE: begin
                if (enable && !srx_q) begin
                    lcr_d     = lcr[5:0];
                    counter_d = 5'd7;
                    state_d   = SR_REC_START;
                end
            end
            SR_REC_START: begin
                if (enable) begin
                    if (counter_q != 5'd0) begin
                        counter_d = counter_q - 5'd1;
                    end else if (srx_q) begin
                        state_d = SR_IDLE;
                    end else begin
                        counter_d     = 5'd15;
                        shift_d       = 8'h00;
                        bit_counter_d = 4'd0;
                        parity_bit_d  = 1'b0;
                        pe_d          = 1'b0;
                        fe_d          = 1'b0;
                        bi_d          = 1'b0;
                        state_d       = SR_REC_BIT;
                    end
                end
            end
            SR_REC_BIT: begin
                if (enable) begin
                    if (counter_q != 5'd0) begin
                        counter_d = counter_q - 5'd1;
                    end else begin
                        shift_d[bit_counter_q[2:0]] = srx_q;
                        bit_counter_d = bit_counter_q + 4'd1;
                        counter_d     = 5'd15;
                        if (bit_counter_q + 4'd1 == char_bits) begin
                            state_d = lcr_q[UART_LC_PE] ? SR_REC_PARITY : SR_REC_STOP;
                        end
                    end
                end
            end
            SR_REC_PARITY: begin
                if (enable) begin
                    if (counter_q != 5'd0) begin
                        counter_d = counter_q - 5'd1;
                    end else begin
                        parity_bit_d = srx_q;
                        pe_d         = srx_q != expected_parity(shift_q, lcr_q[UART_LC_EP], lcr_q[UART_LC_SP]);
                        counter_d    = 5'd15;
                        state_d      = SR_REC_STOP;
                    end
                end
            end
            SR_REC_STOP: begin
                if (enable) begin
                    if (counter_q != 5'd0) begin
                        counter_d = counter_q - 5'd1;
                    end else begin
                        fe_d    = !srx_q || brk;
                        bi_d    = brk;
                        state_d = SR_PUSH;
                    end
                end
            end
            SR_PUSH: begin
                state_d = bi_q ? SR_WAIT_HIGH : SR_IDLE;
            end
            SR_WAIT_HIGH: begin
                if (enable && srx_q) begin
                    state_d = SR_IDLE;
                end
            end
            default: begin
                state_d = SR_IDLE;
            end
        endcase
    end

    always_comb begin
        rf_push = (state_q == SR_PUSH);
        rstate  = state_q;
    end

    assign rf_data_in = {shift_q, pe_q, fe_q, bi_q};

    uart_rfifo u_rfifo (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .push         (rf_push),
        .pop          (rf_pop),
        .data_in      (rf_data_in),
        .fifo_reset   (rx_reset),
        .reset_status (lsr_mask),
        .data_out     (rf_data_out),
        .count        (rf_count),
        .overrun      (rf_overrun)
    );

endmodule
